// File: rtl/cp_pkg.sv
// rtl/cp_pkg.sv - shared constants and types for the command processor FIFO reader
package cp_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned CP_BLOCK_BYTES = 32;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cp_beat_fifo.sv
// rtl/cp_beat_fifo.sv - first-word-fall-through beat buffer with flush and free count
module cp_beat_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push && (count != CW'(DEPTH));
  assign do_pop     = pop_ready && (count != '0);
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign free_count = CW'(DEPTH) - count;

  // Storage, pointers and occupancy; flush drops everything buffered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cp_fifo_reader.sv
// rtl/cp_fifo_reader.sv - command ring fetch engine issuing 32-byte AXI read bursts
module cp_fifo_reader
  import cp_pkg::*;
#(
  parameter int BURST_BEATS = 2,
  parameter int BUF_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [31:0]  fifo_base,
  input  logic [31:0]  fifo_end,
  input  logic [31:0]  write_ptr,
  input  logic         rp_load,
  input  logic [31:0]  rp_load_value,
  output logic [31:0]  read_ptr,
  output logic [31:0]  rw_distance,
  output logic         busy,
  output logic         rd_err,
  output logic [48:0]  araddr_a,
  output logic [7:0]   arlen_a,
  output logic [2:0]   arsize_a,
  output logic [1:0]   arburst_a,
  output logic         arvalid_a,
  input  logic         arready_a,
  input  logic [127:0] rdata_a,
  input  logic [1:0]   rresp_a,
  input  logic         rlast_a,
  input  logic         rvalid_a,
  output logic         rready_a,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int          CW         = $clog2(BUF_DEPTH) + 1;
  localparam logic [31:0] BLOCK_MASK = ~32'(CP_BLOCK_BYTES - 1);

  rd_state_e     state;
  logic          discard;
  logic [CW-1:0] free_count;
  logic [31:0]   base_al;
  logic [31:0]   end_al;
  logic [31:0]   wp_al;
  logic [31:0]   rp_next_block;
  logic          start_burst;
  logic          r_fire;
  logic          push;

  assign base_al = fifo_base & BLOCK_MASK;
  assign end_al  = fifo_end & BLOCK_MASK;
  assign wp_al   = write_ptr & BLOCK_MASK;

  // Space for a whole burst is reserved up front so rready can stay high in DATA.
  assign start_burst = (state == RD_IDLE) && enable && !rp_load &&
                       (read_ptr[31:5] != write_ptr[31:5]) &&
                       (free_count >= CW'(BURST_BEATS));

  assign rp_next_block = (read_ptr[31:5] == fifo_end[31:5]) ? base_al
                                                            : read_ptr + 32'(CP_BLOCK_BYTES);

  assign r_fire = rvalid_a && rready_a;
  // A load in the same cycle as a beat means that beat belongs to the abandoned stream.
  assign push   = r_fire && !discard && !rp_load;
  assign busy   = (state != RD_IDLE);

  // Burst sequencer; AR is held until accepted regardless of enable or load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RD_IDLE;
      arvalid_a <= 1'b0;
      araddr_a  <= '0;
      rready_a  <= 1'b0;
      arlen_a   <= 8'(BURST_BEATS - 1);
      arsize_a  <= AXI_SIZE_16B;
      arburst_a <= AXI_BURST_INCR;
    end else begin
      arlen_a   <= 8'(BURST_BEATS - 1);
      arsize_a  <= AXI_SIZE_16B;
      arburst_a <= AXI_BURST_INCR;
      case (state)
        RD_IDLE: begin
          if (start_burst) begin
            state     <= RD_ADDR;
            arvalid_a <= 1'b1;
            araddr_a  <= {17'b0, read_ptr};
          end
        end
        RD_ADDR: begin
          if (arready_a) begin
            state     <= RD_DATA;
            arvalid_a <= 1'b0;
            rready_a  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_fire && rlast_a) begin
            state    <= RD_IDLE;
            rready_a <= 1'b0;
          end
        end
        default: begin
          state     <= RD_IDLE;
          arvalid_a <= 1'b0;
          rready_a  <= 1'b0;
        end
      endcase
    end
  end

  // Read pointer: a load overrides the advance from a coincident AR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      read_ptr <= '0;
    end else if (rp_load) begin
      read_ptr <= rp_load_value & BLOCK_MASK;
    end else if ((state == RD_ADDR) && arready_a) begin
      read_ptr <= rp_next_block;
    end
  end

  // Discard flag covers the remainder of a burst that was in flight at a load; error is sticky.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard <= 1'b0;
      rd_err  <= 1'b0;
    end else if (rp_load) begin
      rd_err  <= 1'b0;
      discard <= (state == RD_ADDR) || ((state == RD_DATA) && !(r_fire && rlast_a));
    end else begin
      if (r_fire && rlast_a) discard <= 1'b0;
      if (push && (rresp_a != AXI_RESP_OKAY)) rd_err <= 1'b1;
    end
  end

  // Unread byte count with ring wrap; the producer never fills the last block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rw_distance <= '0;
    end else if (wp_al >= read_ptr) begin
      rw_distance <= wp_al - read_ptr;
    end else begin
      rw_distance <= (end_al - read_ptr) + (wp_al - base_al) + 32'(CP_BLOCK_BYTES);
    end
  end

  cp_beat_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (128)
  ) u_beat_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (rp_load),
    .push       (push),
    .push_data  (rdata_a),
    .pop_data   (out_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .free_count (free_count)
  );

endmodule

// File: tb/tb_cp_fifo_reader.sv
// tb/tb_cp_fifo_reader.sv - scoreboard bench for the command ring fetch engine
module tb_cp_fifo_reader;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable;
  logic [31:0]  fifo_base;
  logic [31:0]  fifo_end;
  logic [31:0]  write_ptr;
  logic         rp_load;
  logic [31:0]  rp_load_value;
  logic [31:0]  read_ptr;
  logic [31:0]  rw_distance;
  logic         busy;
  logic         rd_err;
  logic [48:0]  araddr_a;
  logic [7:0]   arlen_a;
  logic [2:0]   arsize_a;
  logic [1:0]   arburst_a;
  logic         arvalid_a;
  logic         arready_a;
  logic [127:0] rdata_a;
  logic [1:0]   rresp_a;
  logic         rlast_a;
  logic         rvalid_a;
  logic         rready_a;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  cp_fifo_reader #(.BURST_BEATS(2), .BUF_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo_base(fifo_base), .fifo_end(fifo_end), .write_ptr(write_ptr),
    .rp_load(rp_load), .rp_load_value(rp_load_value),
    .read_ptr(read_ptr), .rw_distance(rw_distance), .busy(busy), .rd_err(rd_err),
    .araddr_a(araddr_a), .arlen_a(arlen_a), .arsize_a(arsize_a), .arburst_a(arburst_a),
    .arvalid_a(arvalid_a), .arready_a(arready_a),
    .rdata_a(rdata_a), .rresp_a(rresp_a), .rlast_a(rlast_a), .rvalid_a(rvalid_a),
    .rready_a(rready_a),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [31:0]  exp_ar[$];
  logic [127:0] exp_beats[$];
  logic [31:0]  pend[$];
  int           ar_count = 0;
  int           ar_wait  = 0;
  logic [31:0]  err_addr = 32'hFFFF_FFFF;
  int           err_beat = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a, input int i);
    return {a, ~a, 32'h5A5A_0000 + 32'(i), 32'hC0FF_EE00 + 32'(i)};
  endfunction

  task automatic expect_burst(input logic [31:0] a, input bit with_beats);
    exp_ar.push_back(a);
    if (with_beats) begin
      exp_beats.push_back(beat_data(a, 0));
      exp_beats.push_back(beat_data(a, 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_rp(input logic [31:0] v);
    rp_load = 1'b1;
    rp_load_value = v;
    tick();
    rp_load = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy && !arvalid_a && exp_ar.size() == 0 && exp_beats.size() == 0) break;
    end
    repeat (4) tick();
    check({name, "_ar_left"}, exp_ar.size(), 0);
    check({name, "_beats_left"}, exp_beats.size(), 0);
  endtask

  // AXI slave: accepts AR (optionally stalling), returns two beats per burst.
  initial begin : slave
    logic        ar_fire_s;
    logic        r_fire_s;
    logic        prev_stall;
    logic [48:0] prev_araddr;
    logic [31:0] ar_lat;
    int          beat_idx;
    ar_fire_s = 0; r_fire_s = 0; prev_stall = 0; prev_araddr = '0; ar_lat = '0; beat_idx = 0;
    arready_a = 0; rvalid_a = 0; rdata_a = '0; rresp_a = '0; rlast_a = 0;
    forever begin
      @(negedge clk);
      if (r_fire_s) begin
        if (rlast_a) begin
          void'(pend.pop_front());
          beat_idx = 0;
        end else beat_idx++;
      end
      if (ar_fire_s) pend.push_back(ar_lat);
      if (prev_stall) begin
        check("ar_hold_valid", arvalid_a, 1'b1);
        check("ar_hold_addr", araddr_a, prev_araddr);
      end
      if (arvalid_a && ar_wait > 0) begin
        arready_a = 1'b0;
        ar_wait--;
      end else arready_a = arvalid_a;
      prev_stall  = arvalid_a && !arready_a;
      prev_araddr = araddr_a;
      ar_fire_s   = arvalid_a && arready_a;
      if (ar_fire_s) begin
        ar_lat = araddr_a[31:0];
        ar_count++;
        check("ar_expected", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) check("ar_addr", araddr_a, {17'b0, exp_ar.pop_front()});
        check("ar_len", arlen_a, 8'd1);
        check("ar_size", arsize_a, 3'b100);
        check("ar_burst", arburst_a, 2'b01);
      end
      if (pend.size() > 0) begin
        rvalid_a = 1'b1;
        rdata_a  = beat_data(pend[0], beat_idx);
        rlast_a  = (beat_idx == 1);
        rresp_a  = (pend[0] == err_addr && beat_idx == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid_a = 1'b0;
        rlast_a  = 1'b0;
        rresp_a  = 2'b00;
      end
      r_fire_s = rvalid_a && rready_a;
    end
  end

  // Monitor: every beat handed to the parser must match the head of the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        check("beat_expected", exp_beats.size() != 0, 1'b1);
        if (exp_beats.size() != 0) check("beat_data", out_data, exp_beats.pop_front());
      end
    end
  end

  initial begin : stim
    int  base_cnt;
    bit  found;
    resetn = 0; enable = 0; fifo_base = 0; fifo_end = 0; write_ptr = 0;
    rp_load = 0; rp_load_value = 0; out_ready = 0;
    repeat (3) tick();
    check("rst_arvalid", arvalid_a, 1'b0);
    check("rst_rready", rready_a, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_read_ptr", read_ptr, 32'h0);
    check("rst_rw_distance", rw_distance, 32'h0);
    check("rst_araddr", araddr_a, 49'h0);
    check("rst_arlen", arlen_a, 8'd1);
    check("rst_arsize", arsize_a, 3'b100);
    check("rst_arburst", arburst_a, 2'b01);
    check("rst_out_data", out_data, 128'h0);
    resetn = 1;
    tick();

    // Two sequential blocks
    fifo_base = 32'h1000; fifo_end = 32'h10E0; write_ptr = 32'h1040; out_ready = 1;
    load_rp(32'h1000);
    check("t1_read_ptr_load", read_ptr, 32'h1000);
    check("t1_dist_init", rw_distance, 32'h40);
    expect_burst(32'h1000, 1);
    expect_burst(32'h1020, 1);
    enable = 1;
    wait_done("t1");
    check("t1_read_ptr_final", read_ptr, 32'h1040);
    check("t1_dist_final", rw_distance, 32'h0);

    // Wrap from the last block back to base
    enable = 0;
    write_ptr = 32'h1020;
    load_rp(32'h10E0);
    check("t2_dist_init", rw_distance, 32'h40);
    expect_burst(32'h10E0, 1);
    expect_burst(32'h1000, 1);
    enable = 1;
    wait_done("t2");
    check("t2_read_ptr_final", read_ptr, 32'h1020);

    // Backpressure: only four bursts fit in eight entries
    enable = 0; out_ready = 0;
    fifo_base = 32'h2000; fifo_end = 32'h2FE0; write_ptr = 32'h2200;
    load_rp(32'h2000);
    check("t3_dist_init", rw_distance, 32'h200);
    for (int k = 0; k < 16; k++) expect_burst(32'h2000 + 32'(k * 32), 1);
    base_cnt = ar_count;
    enable = 1;
    repeat (60) tick();
    check("t3_bursts_stalled", ar_count - base_cnt, 4);
    check("t3_busy_stalled", busy, 1'b0);
    check("t3_out_valid_stalled", out_valid, 1'b1);
    out_ready = 1;
    wait_done("t3");
    check("t3_read_ptr_final", read_ptr, 32'h2200);

    // AR stall with enable dropped during the wait
    enable = 0;
    fifo_base = 32'h1000; fifo_end = 32'h10E0; write_ptr = 32'h1060;
    load_rp(32'h1000);
    ar_wait = 5;
    expect_burst(32'h1000, 1);
    base_cnt = ar_count;
    enable = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (arvalid_a) begin found = 1; break; end
    end
    check("t4_arvalid_seen", found, 1'b1);
    enable = 0;
    wait_done("t4");
    repeat (20) tick();
    check("t4_bursts", ar_count - base_cnt, 1);
    check("t4_read_ptr", read_ptr, 32'h1020);
    check("t4_dist", rw_distance, 32'h40);
    check("t4_busy", busy, 1'b0);

    // Pointer load while data is in flight
    enable = 0;
    write_ptr = 32'h10C0;
    load_rp(32'h1000);
    expect_burst(32'h1000, 0);
    expect_burst(32'h1080, 1);
    expect_burst(32'h10A0, 1);
    enable = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && !arvalid_a) begin found = 1; break; end
    end
    check("t5_reach_data", found, 1'b1);
    rp_load = 1; rp_load_value = 32'h1080;
    tick();
    rp_load = 0;
    check("t5_out_valid_a", out_valid, 1'b0);
    tick();
    check("t5_out_valid_b", out_valid, 1'b0);
    wait_done("t5");
    check("t5_read_ptr", read_ptr, 32'h10C0);
    check("t5_rd_err", rd_err, 1'b0);

    // Slave error on one beat
    enable = 0;
    write_ptr = 32'h10E0;
    load_rp(32'h10C0);
    err_addr = 32'h10C0; err_beat = 1;
    expect_burst(32'h10C0, 1);
    enable = 1;
    wait_done("t6");
    check("t6_rd_err_set", rd_err, 1'b1);
    check("t6_read_ptr", read_ptr, 32'h10E0);
    enable = 0;
    load_rp(32'h10E0);
    check("t6_rd_err_cleared", rd_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
